// File: rtl/imm_encoder_if.sv
// Request/response handshake bundle for the immediate encoder.
// The master side issues requests and consumes results; the slave side is the encoder.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_imm;
    logic [2:0]  in_imm_type;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [2:0]  out_err;

    modport master (
        output in_valid, in_instr, in_imm, in_imm_type, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_instr, in_imm, in_imm_type, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage RV32I immediate encoder: patches an immediate into a base instruction word
// and flags range, alignment and type errors, with saturating hand-off statistics.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_encoder_if.slave     bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_done,
    output logic [CNT_W-1:0] cnt_err
);

    localparam logic [2:0] TYPE_I = 3'b000;
    localparam logic [2:0] TYPE_S = 3'b001;
    localparam logic [2:0] TYPE_B = 3'b010;
    localparam logic [2:0] TYPE_J = 3'b011;
    localparam logic [2:0] TYPE_U = 3'b100;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic        s1_valid;
    logic [31:0] s1_instr;
    logic [31:0] s1_imm;
    logic [2:0]  s1_type;
    logic        s1_range_err;
    logic        s1_align_err;
    logic        s1_type_err;

    logic        s2_valid;
    logic [31:0] s2_instr;
    logic [2:0]  s2_err;

    logic        in_range_err;
    logic        in_align_err;
    logic        in_type_err;
    logic [31:0] patched;

    logic        s2_load;
    logic        s1_load;
    logic        out_hs;

    assign s2_load = !s2_valid || bus.out_ready;
    assign s1_load = !s1_valid || s2_load;
    assign out_hs  = s2_valid && bus.out_ready;

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid;
    assign bus.out_instr = s2_instr;
    assign bus.out_err   = s2_err;

    // Error flags are resolved on the raw request so S2 only has to do field placement.
    always_comb begin
        in_range_err = 1'b0;
        in_align_err = 1'b0;
        in_type_err  = 1'b0;
        case (bus.in_imm_type)
            TYPE_I, TYPE_S: begin
                in_range_err = bus.in_imm != {{20{bus.in_imm[11]}}, bus.in_imm[11:0]};
            end
            TYPE_B: begin
                in_range_err = bus.in_imm != {{19{bus.in_imm[12]}}, bus.in_imm[12:0]};
                in_align_err = bus.in_imm[0];
            end
            TYPE_J: begin
                in_range_err = bus.in_imm != {{11{bus.in_imm[20]}}, bus.in_imm[20:0]};
                in_align_err = bus.in_imm[0];
            end
            TYPE_U: begin
                in_range_err = |bus.in_imm[11:0];
            end
            default: begin
                in_type_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        patched = s1_instr;
        case (s1_type)
            TYPE_I: begin
                patched[31:20] = s1_imm[11:0];
            end
            TYPE_S: begin
                patched[31:25] = s1_imm[11:5];
                patched[11:7]  = s1_imm[4:0];
            end
            TYPE_B: begin
                patched[31]    = s1_imm[12];
                patched[30:25] = s1_imm[10:5];
                patched[11:8]  = s1_imm[4:1];
                patched[7]     = s1_imm[11];
            end
            TYPE_J: begin
                patched[31]    = s1_imm[20];
                patched[30:21] = s1_imm[10:1];
                patched[20]    = s1_imm[11];
                patched[19:12] = s1_imm[19:12];
            end
            TYPE_U: begin
                patched[31:12] = s1_imm[31:12];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_instr     <= '0;
            s1_imm       <= '0;
            s1_type      <= '0;
            s1_range_err <= 1'b0;
            s1_align_err <= 1'b0;
            s1_type_err  <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_instr     <= bus.in_instr;
                s1_imm       <= bus.in_imm;
                s1_type      <= bus.in_imm_type;
                s1_range_err <= in_range_err;
                s1_align_err <= in_align_err;
                s1_type_err  <= in_type_err;
            end
        end
    end

    // Payload only moves when a real item arrives, so a stalled result stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr <= patched;
                s2_err   <= {s1_type_err, s1_align_err, s1_range_err};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_done <= '0;
            cnt_err  <= '0;
        end else if (clr_cnt) begin
            cnt_done <= '0;
            cnt_err  <= '0;
        end else if (out_hs) begin
            if (cnt_done != CNT_MAX) begin
                cnt_done <= cnt_done + CNT_ONE;
            end
            if ((s2_err != 3'b000) && (cnt_err != CNT_MAX)) begin
                cnt_err <= cnt_err + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors, backpressure, counters, reset and
// a random encode/decode round trip against the core's sign-extension rules.
module tb_imm_encoder;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_ALL = {CNT_W{1'b1}};

    typedef struct {
        bit          rt;
        logic [31:0] instr;
        logic [2:0]  err;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic [31:0] base;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic [31:0] exp_instr;
        logic [2:0]  exp_err;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             clr_cnt;
    logic [CNT_W-1:0] cnt_done;
    logic [CNT_W-1:0] cnt_err;

    int   checks;
    int   errors;
    exp_t exp_q[$];

    imm_encoder_if bus();

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .clr_cnt  (clr_cnt),
        .cnt_done (cnt_done),
        .cnt_err  (cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [31:0] instr, input logic [2:0] err);
        exp_t e;
        e.rt    = 1'b0;
        e.instr = instr;
        e.err   = err;
        e.imm   = '0;
        e.typ   = '0;
        e.base  = '0;
        return e;
    endfunction

    // The core's sign-extension unit, used to decode results independently of the encoder.
    function automatic logic [31:0] decode_imm(input logic [31:0] x, input logic [2:0] typ);
        case (typ)
            3'b000:  return {{20{x[31]}}, x[31:20]};
            3'b001:  return {{20{x[31]}}, x[31:25], x[11:7]};
            3'b010:  return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            3'b011:  return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
            default: return {x[31:12], 12'h000};
        endcase
    endfunction

    function automatic logic [31:0] keep_mask(input logic [2:0] typ);
        case (typ)
            3'b000:         return 32'h000F_FFFF;
            3'b001, 3'b010: return 32'h01FF_F07F;
            default:        return 32'h0000_0FFF;
        endcase
    endfunction

    // Called right after a rising edge; returns right after the edge that accepted the item.
    task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] imm,
                                  input logic [2:0] typ, input exp_t e);
        bit accepted;
        accepted        = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_instr    = instr;
        bus.in_imm      = imm;
        bus.in_imm_type = typ;
        for (int c = 0; c < 1000 && !accepted; c++) begin
            @(negedge clk);
            accepted = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (accepted) begin
            exp_q.push_back(e);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 1000 cycles");
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            if (exp_q.size() == 0 && !bus.out_valid) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    // Monitor: compares each result as it is handed off, and the held result during stalls.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got 0x%08h, expected no output", bus.out_instr);
            end else if (!bus.out_ready) begin
                if (!exp_q[0].rt) begin
                    check_output("stall_hold_instr", bus.out_instr, exp_q[0].instr);
                    check_output("stall_hold_err", {29'd0, bus.out_err}, {29'd0, exp_q[0].err});
                end
            end else begin
                e = exp_q.pop_front();
                if (e.rt) begin
                    checks++;
                    if (decode_imm(bus.out_instr, e.typ) !== e.imm || bus.out_err !== 3'b000 ||
                        (bus.out_instr & keep_mask(e.typ)) !== (e.base & keep_mask(e.typ))) begin
                        errors++;
                        $display("[TB] FAIL round_trip: got instr 0x%08h err %b decoded 0x%08h, expected imm 0x%08h type %b base 0x%08h err 000",
                                 bus.out_instr, bus.out_err, decode_imm(bus.out_instr, e.typ), e.imm, e.typ, e.base);
                    end
                end else begin
                    check_output("result_instr", bus.out_instr, e.instr);
                    check_output("result_err", {29'd0, bus.out_err}, {29'd0, e.err});
                end
            end
        end
    end

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{32'h0000_0013, 32'hFFFF_F800, 3'b000, 32'h8000_0013, 3'b000};
        vecs[1]  = '{32'h0000_0013, 32'h0000_0800, 3'b000, 32'h8000_0013, 3'b001};
        vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0000, 3'b000, 32'h000F_FFFF, 3'b000};
        vecs[3]  = '{32'h0000_0023, 32'hFFFF_FFFC, 3'b001, 32'hFE00_0E23, 3'b000};
        vecs[4]  = '{32'h0000_0063, 32'h0000_0008, 3'b010, 32'h0000_0463, 3'b000};
        vecs[5]  = '{32'h0000_0063, 32'h0000_1000, 3'b010, 32'h8000_0063, 3'b001};
        vecs[6]  = '{32'h0000_0063, 32'h0000_0003, 3'b010, 32'h0000_0163, 3'b010};
        vecs[7]  = '{32'h0000_006F, 32'h0000_0800, 3'b011, 32'h0010_006F, 3'b000};
        vecs[8]  = '{32'h0000_006F, 32'h0010_0000, 3'b011, 32'h8000_006F, 3'b001};
        vecs[9]  = '{32'h0000_0037, 32'h1234_5000, 3'b100, 32'h1234_5037, 3'b000};
        vecs[10] = '{32'h0000_0037, 32'h1234_5001, 3'b100, 32'h1234_5037, 3'b001};
        vecs[11] = '{32'hDEAD_BEEF, 32'h0000_0001, 3'b111, 32'hDEAD_BEEF, 3'b100};
    end

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        clr_cnt         = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_instr    = '0;
        bus.in_imm      = '0;
        bus.in_imm_type = '0;
        bus.out_ready   = 1'b1;

        #1;
        check_output("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_output("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_output("reset_out_instr", bus.out_instr, 32'd0);
        check_output("reset_out_err", {29'd0, bus.out_err}, 32'd0);
        check_output("reset_cnt_done", {28'd0, cnt_done}, 32'd0);
        check_output("reset_cnt_err", {28'd0, cnt_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_output("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Directed encodings issued back to back.
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].instr, vecs[i].imm, vecs[i].typ,
                           mk_exp(vecs[i].exp_instr, vecs[i].exp_err));
        end
        wait_drain();

        // Result visible two edges after the request is first driven, not one.
        apply_stimulus(32'h0000_0013, 32'h0000_0005, 3'b000, mk_exp(32'h0050_0013, 3'b000));
        check_output("latency_one_edge", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check_output("latency_two_edges", {31'd0, bus.out_valid}, 32'd1);
        wait_drain();

        // Backpressure: six items, downstream stalled for three cycles.
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    apply_stimulus(32'h0000_0013 | (32'(i) << 7), 32'(i),
                                   3'b000, mk_exp((32'(i) << 20) | (32'(i) << 7) | 32'h13, 3'b000));
                end
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                check_output("bp_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        check_output("bp_cnt_done", {28'd0, cnt_done}, 32'd6);
        check_output("bp_cnt_err", {28'd0, cnt_err}, 32'd0);

        // Saturation with more errored items than the counters can hold.
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(32'hDEAD_BEEF, 32'(i), 3'b101, mk_exp(32'hDEAD_BEEF, 3'b100));
        end
        wait_drain();
        check_output("sat_cnt_done", {28'd0, cnt_done}, {28'd0, CNT_ALL});
        check_output("sat_cnt_err", {28'd0, cnt_err}, {28'd0, CNT_ALL});

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        apply_stimulus(32'h0000_0013, 32'h0000_0001, 3'b000, mk_exp(32'h0010_0013, 3'b000));
        apply_stimulus(32'h0000_0013, 32'h0000_0002, 3'b000, mk_exp(32'h0020_0013, 3'b000));
        check_output("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_output("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_output("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_output("midrst_cnt_done", {28'd0, cnt_done}, 32'd0);
        check_output("midrst_cnt_err", {28'd0, cnt_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_output("post_midrst_no_stale", {31'd0, bus.out_valid}, 32'd0);
        check_output("post_midrst_cnt_done", {28'd0, cnt_done}, 32'd0);

        // Clear coincides with a hand-off: clear wins.
        apply_stimulus(32'h1111_1111, 32'h0, 3'b110, mk_exp(32'h1111_1111, 3'b100));
        apply_stimulus(32'h2222_2222, 32'h0, 3'b110, mk_exp(32'h2222_2222, 3'b100));
        wait_drain();
        check_output("pre_clr_cnt_done", {28'd0, cnt_done}, 32'd2);
        bus.out_ready = 1'b0;
        apply_stimulus(32'h3333_3333, 32'h0, 3'b110, mk_exp(32'h3333_3333, 3'b100));
        for (int c = 0; c < 10 && !bus.out_valid; c++) begin
            @(posedge clk);
            #1;
        end
        check_output("clr_item_waiting", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        clr_cnt       = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check_output("clr_prio_cnt_done", {28'd0, cnt_done}, 32'd0);
        check_output("clr_prio_cnt_err", {28'd0, cnt_err}, 32'd0);
        wait_drain();

        // Random representable immediates, decoded back through the sign-extension rules.
        for (int i = 0; i < 10000; i++) begin
            exp_t        e;
            logic [31:0] r;
            r      = $urandom;
            e.rt   = 1'b1;
            e.typ  = 3'($urandom_range(0, 4));
            e.base = $urandom;
            case (e.typ)
                3'b000, 3'b001: e.imm = {{20{r[11]}}, r[11:0]};
                3'b010:         e.imm = {{19{r[12]}}, r[12:1], 1'b0};
                3'b011:         e.imm = {{11{r[20]}}, r[20:1], 1'b0};
                default:        e.imm = {r[31:12], 12'h000};
            endcase
            e.instr = '0;
            e.err   = '0;
            apply_stimulus(e.base, e.imm, e.typ, e);
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
